// File: rtl/fifo_burst_rd.sv
// Read-side burst controller for the FIFO test path. A burst starts once the
// synchronised full flag is seen. It ends on almost_empty, empty or a fixed beat count.
module fifo_burst_rd #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BURST_LEN   = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              full,
  input  logic              almost_empty,
  input  logic              empty,
  input  logic              rd_rst_busy,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              burst_done,
  output logic              busy,
  output logic [1:0]        state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BEAT =
    (BURST_LEN == 0) ? '0 : CNT_W'(BURST_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   full_s;
  logic                   rd_iss;
  logic                   iss_q;
  logic                   stop;
  logic [CNT_W-1:0]       beats;
  logic [1:0]             state_nx;
  logic                   en_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], full};
  end

  assign full_s = sync_q[SYNC_STAGES-1];

  // fifo_rd_en is only a request: a word moves (rd_iss) when it is high and
  // the FIFO is non-empty; that word appears on fifo_rd_data one cycle later.
  assign rd_iss = fifo_rd_en & ~empty;
  assign stop   = almost_empty | empty |
                  ((BURST_LEN != 0) & rd_iss & (beats == LAST_BEAT));

  always_comb begin
    state_nx = state;
    en_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (full_s && !rd_rst_busy) begin
          state_nx = READ;
          en_nx    = 1'b1;
        end
      end
      READ: begin
        if (rd_rst_busy)  state_nx = IDLE;
        else if (stop)    state_nx = DONE;
        else              en_nx    = 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fifo_rd_en <= 1'b0;
      beats      <= '0;
      burst_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      fifo_rd_en <= en_nx;
      burst_done <= (state == DONE);
      busy       <= (state_nx != IDLE);
      if (state == IDLE && state_nx == READ) beats <= '0;
      else if (rd_iss)                       beats <= beats + CNT_W'(1);
    end
  end

  // A read-side reset discards whatever word is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      rd_cnt     <= '0;
    end else if (rd_rst_busy) begin
      iss_q      <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      iss_q      <= rd_iss;
      dout_valid <= iss_q;
      if (iss_q) begin
        dout   <= fifo_rd_data;
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_rd.sv
// Bench for fifo_burst_rd: DUT a drains to almost_empty (BURST_LEN=0, CNT_W=16),
// DUT b runs fixed 4-beat bursts with a 4-bit word counter.
module tb_fifo_burst_rd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rd_rst_busy;

  logic       full_a, almost_a, empty_a, en_a, dv_a, bd_a, busy_a, force_empty_a;
  logic [7:0] rdata_a = '0, dout_a;
  logic [15:0] cnt_a;
  logic [1:0] st_a;

  logic       full_b, almost_b, empty_b, en_b, dv_b, bd_b, busy_b;
  logic [7:0] rdata_b = '0, dout_b;
  logic [3:0] cnt_b;
  logic [1:0] st_b;

  fifo_burst_rd #(.DATA_W(8), .SYNC_STAGES(2), .BURST_LEN(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .full(full_a), .almost_empty(almost_a), .empty(empty_a),
    .rd_rst_busy(rd_rst_busy), .fifo_rd_data(rdata_a), .fifo_rd_en(en_a), .dout(dout_a),
    .dout_valid(dv_a), .rd_cnt(cnt_a), .burst_done(bd_a), .busy(busy_a), .state(st_a)
  );

  fifo_burst_rd #(.DATA_W(8), .SYNC_STAGES(2), .BURST_LEN(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .full(full_b), .almost_empty(almost_b), .empty(empty_b),
    .rd_rst_busy(rd_rst_busy), .fifo_rd_data(rdata_b), .fifo_rd_en(en_b), .dout(dout_b),
    .dout_valid(dv_b), .rd_cnt(cnt_b), .burst_done(bd_b), .busy(busy_b), .state(st_b)
  );

  // Behavioural standard-mode FIFOs: the word is presented the cycle after a read.
  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:255];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

  assign empty_a  = (wr_a == rd_a) || force_empty_a;
  assign almost_a = ((wr_a - rd_a) == 1) && !force_empty_a;
  assign empty_b  = (wr_b == rd_b);
  assign almost_b = ((wr_b - rd_b) == 1);

  always @(posedge clk) begin
    if (en_a && !empty_a) begin
      rdata_a <= mem_a[rd_a[7:0]];
      rd_a    <= rd_a + 1;
    end
    if (en_b && !empty_b) begin
      rdata_b <= mem_b[rd_b[7:0]];
      rd_b    <= rd_b + 1;
    end
  end

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int checks = 0, errors = 0;
  int cnt_exp_a = 0, cnt_exp_b = 0;
  int n_valid_a = 0, n_valid_b = 0, n_bd_a = 0, n_bd_b = 0, n_iss_a = 0, nen_b = 0;
  logic [7:0] bd_dout_a = '0;
  logic       bd_dv_a = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem_a[wr_a[7:0]] = base + 8'(i);
      wr_a = wr_a + 1;
      exp_a.push_back(base + 8'(i));
    end
  endtask

  task automatic load_b(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem_b[wr_b[7:0]] = base + 8'(i);
      wr_b = wr_b + 1;
      exp_b.push_back(base + 8'(i));
    end
  endtask

  // Advance to the next falling edge and score whatever both DUTs present.
  task automatic step();
    @(negedge clk);
    if (dv_a) begin
      chk("a_word_expected", 32'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) chk("a_dout", dout_a, exp_a.pop_front());
      n_valid_a++;
      cnt_exp_a++;
      chk("a_rd_cnt", cnt_a, 32'(cnt_exp_a & 16'hFFFF));
    end
    if (en_a && !empty_a) n_iss_a++;
    if (bd_a) begin
      n_bd_a++;
      bd_dout_a = dout_a;
      bd_dv_a   = dv_a;
    end
    if (dv_b) begin
      chk("b_word_expected", 32'(exp_b.size() != 0), 1);
      if (exp_b.size() != 0) chk("b_dout", dout_b, exp_b.pop_front());
      n_valid_b++;
      cnt_exp_b++;
      chk("b_rd_cnt", cnt_b, 32'(cnt_exp_b & 15));
    end
    if (en_b) nen_b++;
    if (bd_b) n_bd_b++;
  endtask

  task automatic wait_en_a(input int limit);
    for (int i = 0; i < limit && !en_a; i++) step();
    chk("a_en_rise", en_a, 1);
  endtask

  task automatic wait_en_b(input int limit);
    for (int i = 0; i < limit && !en_b; i++) step();
    chk("b_en_rise", en_b, 1);
  endtask

  task automatic wait_bd_a(input string tag, input int limit);
    int n0 = n_bd_a;
    for (int i = 0; i < limit && n_bd_a == n0; i++) step();
    chk(tag, n_bd_a, n0 + 1);
  endtask

  task automatic chk_zero_a(input string t);
    chk({t, "_a_en"}, en_a, 0);     chk({t, "_a_dout"}, dout_a, 0);
    chk({t, "_a_dv"}, dv_a, 0);     chk({t, "_a_cnt"}, cnt_a, 0);
    chk({t, "_a_bd"}, bd_a, 0);     chk({t, "_a_busy"}, busy_a, 0);
    chk({t, "_a_state"}, st_a, 0);
  endtask

  task automatic chk_zero_b(input string t);
    chk({t, "_b_en"}, en_b, 0);     chk({t, "_b_dout"}, dout_b, 0);
    chk({t, "_b_dv"}, dv_b, 0);     chk({t, "_b_cnt"}, cnt_b, 0);
    chk({t, "_b_bd"}, bd_b, 0);     chk({t, "_b_busy"}, busy_b, 0);
    chk({t, "_b_state"}, st_b, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int lvl;
    rst_n = 1'b0; rd_rst_busy = 1'b0; full_a = 1'b0; full_b = 1'b0; force_empty_a = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_a("reset");
    chk_zero_b("reset");
    rst_n = 1'b1;

    // Drain to almost_empty: en rises on the third edge after full.
    load_a(8'h00, 16);
    full_a = 1'b1;
    step(); step();
    chk("a_full_to_en_2edges", en_a, 0);
    step();
    chk("a_full_to_en_3edges", en_a, 1);
    full_a = 1'b0;
    n_valid_a = 0;
    n0 = n_bd_a;
    wait_bd_a("a_drain_bd", 60);
    chk("a_drain_valid_cnt", n_valid_a, 16);
    chk("a_drain_bd_dout", bd_dout_a, 8'h0F);
    chk("a_drain_bd_with_valid", bd_dv_a, 1);
    chk("a_drain_rd_cnt", cnt_a, 16);
    repeat (4) step();
    chk("a_drain_busy", busy_a, 0);
    chk("a_drain_idle", st_a, 0);
    chk("a_drain_bd_once", n_bd_a, n0 + 1);
    chk("a_drain_exp_left", exp_a.size(), 0);

    // Fixed four-beat burst on b.
    load_b(8'h40, 16);
    nen_b = 0; n_valid_b = 0; n0 = n_bd_b;
    full_b = 1'b1;
    wait_en_b(10);
    full_b = 1'b0;
    for (int i = 0; i < 40 && n_bd_b == n0; i++) step();
    chk("b_fixed_bd", n_bd_b, n0 + 1);
    chk("b_fixed_en_cycles", nen_b, 4);
    chk("b_fixed_valid_cnt", n_valid_b, 4);
    repeat (4) step();
    chk("b_fixed_rd_cnt", cnt_b, 4);
    chk("b_fixed_busy", busy_b, 0);
    chk("b_fixed_idle", st_b, 0);
    chk("b_fixed_bd_once", n_bd_b, n0 + 1);
    chk("b_fixed_exp_left", exp_b.size(), 12);

    // Empty forced after five issued reads; the empty cycle is not a read.
    load_a(8'h20, 12);
    n_iss_a = 0; n_valid_a = 0;
    full_a = 1'b1;
    wait_en_a(10);
    full_a = 1'b0;
    for (int i = 0; i < 20 && n_iss_a < 5; i++) step();
    @(posedge clk);
    #1 force_empty_a = 1'b1;
    step();
    chk("a_empty_en_same_cycle", en_a, 1);
    step();
    chk("a_empty_en_drop", en_a, 0);
    wait_bd_a("a_empty_bd", 20);
    chk("a_empty_iss_cnt", n_iss_a, 5);
    chk("a_empty_valid_cnt", n_valid_a, 5);
    chk("a_empty_last_dout", dout_a, 8'h24);
    force_empty_a = 1'b0;
    repeat (3) step();
    chk("a_empty_exp_left", exp_a.size(), 7);

    // Read-side reset after the seventh word: the next two issued words are lost.
    load_a(8'h30, 13);
    n_valid_a = 0;
    full_a = 1'b1;
    wait_en_a(10);
    for (int i = 0; i < 30 && n_valid_a < 7; i++) step();
    chk("a_abort_reached_7", n_valid_a, 7);
    rd_rst_busy = 1'b1;
    full_a = 1'b0;
    n0 = n_bd_a;
    step();
    chk("a_abort_en", en_a, 0);
    chk("a_abort_dv", dv_a, 0);
    chk("a_abort_state", st_a, 0);
    chk("a_abort_busy", busy_a, 0);
    step();
    chk("a_abort_hold_state1", st_a, 0);
    step();
    chk("a_abort_hold_state2", st_a, 0);
    chk("a_abort_hold_en", en_a, 0);
    rd_rst_busy = 1'b0;
    repeat (4) step();
    chk("a_abort_no_bd", n_bd_a, n0);
    chk("a_abort_idle", st_a, 0);
    chk("a_abort_exp_left", exp_a.size(), 13);
    void'(exp_a.pop_front());
    void'(exp_a.pop_front());

    // Asynchronous reset in the middle of a burst.
    full_a = 1'b1;
    wait_en_a(10);
    full_a = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk_zero_a("arst");
    chk_zero_b("arst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_a.delete();
    for (int i = rd_a; i < wr_a; i++) exp_a.push_back(mem_a[i[7:0]]);
    cnt_exp_a = 0;
    cnt_exp_b = 0;

    // Counter wrap on b: 18 words through a 4-bit counter.
    load_b(8'h50, 6);
    n_valid_b = 0;
    full_b = 1'b1;
    for (int i = 0; i < 300 && exp_b.size() != 0; i++) step();
    full_b = 1'b0;
    repeat (10) step();
    chk("b_wrap_valid_cnt", n_valid_b, 18);
    chk("b_wrap_rd_cnt", cnt_b, 2);
    chk("b_wrap_busy", busy_b, 0);
    chk("b_wrap_exp_left", exp_b.size(), 0);

    // A sub-period full pulse between edges is never sampled.
    load_a(8'h60, 4);
    n0 = n_bd_a;
    @(negedge clk);
    #1 full_a = 1'b1;
    #3 full_a = 1'b0;
    repeat (6) step();
    chk("a_short_pulse_en", en_a, 0);
    chk("a_short_pulse_state", st_a, 0);
    chk("a_short_pulse_no_bd", n_bd_a, n0);

    // A one-cycle full pulse starts one complete burst.
    lvl = exp_a.size();
    n_valid_a = 0;
    full_a = 1'b1;
    step();
    full_a = 1'b0;
    wait_bd_a("a_glitch_bd", 80);
    repeat (6) step();
    chk("a_glitch_bd_once", n_bd_a, n0 + 1);
    chk("a_glitch_valid_cnt", n_valid_a, lvl);
    chk("a_glitch_exp_left", exp_a.size(), 0);
    chk("a_glitch_busy", busy_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
